// File: rtl/fetch_unit_if.sv
// Instruction bus between the fetch unit (master) and the memory side (slave).
// Two-phase handshake: the request is accepted with addr_ok, and the word
// comes back with data_ok in the same or a later cycle.
interface fetch_unit_if;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  ibus_req_t  ireq;
  ibus_resp_t iresp;

  modport master (output ireq, input iresp);
  modport slave  (input ireq, output iresp);

endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: commits a next-PC, issues one bus read and hands
// the fetched word plus its PC to decode over a valid/ready handshake.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_BOOT | just out of reset, launches the fetch at RESET_PC
// S_IDLE | waiting for a next-PC offer (in_ready=1)
// S_ADDR | request on the bus, waiting for addr_ok
// S_DATA | address accepted, waiting for data_ok
// S_DONE | result presented to decode, waiting for out_ready
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  fetch_unit_if.master ibus,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_next_pc,
  output logic [31:0] out_instr,
  output logic        out_misaligned,
  output logic [31:0] perf_stall
);

  typedef enum logic [2:0] {
    S_BOOT = 3'd0,
    S_IDLE = 3'd1,
    S_ADDR = 3'd2,
    S_DATA = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic [31:0] instr, instr_next;
  logic        misaligned, misaligned_next;
  logic [31:0] stall_next;

  // State and datapath registers; reset abandons any outstanding transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_BOOT;
      pc         <= RESET_PC;
      instr      <= '0;
      misaligned <= 1'b0;
      perf_stall <= '0;
    end else begin
      state      <= state_next;
      pc         <= pc_next;
      instr      <= instr_next;
      misaligned <= misaligned_next;
      perf_stall <= stall_next;
    end
  end

  // Next-state and register-update decode. A data_ok seen in S_ADDR without
  // addr_ok belongs to an abandoned request and is dropped.
  always_comb begin
    state_next      = state;
    pc_next         = pc;
    instr_next      = instr;
    misaligned_next = misaligned;
    stall_next      = perf_stall;
    case (state)
      S_BOOT: state_next = S_ADDR;
      S_IDLE: begin
        if (in_valid) begin
          pc_next = in_pc;
          if (in_pc[1:0] != 2'b00) begin
            misaligned_next = 1'b1;
            instr_next      = '0;
            state_next      = S_DONE;
          end else begin
            misaligned_next = 1'b0;
            state_next      = S_ADDR;
          end
        end
      end
      S_ADDR: begin
        if (ibus.iresp.addr_ok) begin
          if (ibus.iresp.data_ok) begin
            instr_next = ibus.iresp.data;
            state_next = S_DONE;
          end else begin
            state_next = S_DATA;
          end
        end else begin
          stall_next = perf_stall + 32'd1;
        end
      end
      S_DATA: begin
        if (ibus.iresp.data_ok) begin
          instr_next = ibus.iresp.data;
          state_next = S_DONE;
        end else begin
          stall_next = perf_stall + 32'd1;
        end
      end
      S_DONE: begin
        if (out_ready) state_next = S_IDLE;
      end
      default: state_next = S_BOOT;
    endcase
  end

  // Handshake outputs decode only the registered state; reset forces them low
  // so nothing leaks out before the first clock edge has loaded S_BOOT.
  always_comb begin
    ibus.ireq.valid = (state == S_ADDR) && !reset;
    ibus.ireq.addr  = pc;
    in_ready        = (state == S_IDLE) && !reset;
    out_valid       = (state == S_DONE) && !reset;
  end

  assign out_pc         = pc;
  assign out_next_pc    = pc + 32'd4;
  assign out_instr      = instr;
  assign out_misaligned = misaligned;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed plus randomized bench for fetch_unit: a transaction-level model
// predicts each result and the cycle it appears in.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'hbfc0_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc, out_next_pc, out_instr, perf_stall;
  logic        out_misaligned;

  int          vectors = 0;
  int          errors = 0;
  logic [31:0] exp_stall = '0;

  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_pc          (in_pc),
    .ibus           (bus),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_next_pc    (out_next_pc),
    .out_instr      (out_instr),
    .out_misaligned (out_misaligned),
    .perf_stall     (perf_stall)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] next_pc_of(input logic [31:0] pc);
    longint unsigned s;
    s = (longint'(pc) + 4) % 64'h1_0000_0000;
    return s[31:0];
  endfunction

  task automatic check_boot();
    chk("boot_in_ready", in_ready, 0);
    chk("boot_ireq_valid", bus.ireq.valid, 0);
    chk("boot_out_valid", out_valid, 0);
    chk("boot_perf_stall", perf_stall, 0);
  endtask

  // Result must be present now, stay frozen for `hold` cycles of backpressure,
  // and in_ready must rise only in the cycle after the handoff.
  task automatic check_done(input logic [31:0] pc, input logic [31:0] instr,
                            input logic mis, input int hold);
    for (int h = 0; h <= hold; h++) begin
      chk("out_valid", out_valid, 1);
      chk("out_pc", out_pc, pc);
      chk("out_next_pc", out_next_pc, next_pc_of(pc));
      chk("out_instr", out_instr, instr);
      chk("out_misaligned", out_misaligned, mis);
      chk("perf_stall", perf_stall, exp_stall);
      chk("done_in_ready", in_ready, 0);
      chk("done_ireq_valid", bus.ireq.valid, 0);
      if (h < hold) begin
        out_ready = 1'b0;
        in_valid  = 1'($urandom_range(0, 1));
        in_pc     = $urandom;
      end else begin
        out_ready = 1'b1;
        in_valid  = 1'b0;
      end
      step();
    end
    out_ready = 1'b0;
    chk("handoff_out_valid", out_valid, 0);
    chk("handoff_in_ready", in_ready, 1);
    chk("handoff_ireq_valid", bus.ireq.valid, 0);
  endtask

  // Bus side of one fetch. The caller has set up the cycle before the first
  // request cycle. a = addr wait cycles; d < 0 means data_ok with addr_ok,
  // otherwise d data wait cycles after addr_ok.
  task automatic bus_fetch(input logic [31:0] pc, input int a, input int d,
                           input logic [31:0] word, input int hold);
    step();
    in_valid = 1'b0;
    for (int i = 0; i <= a; i++) begin
      chk("addr_ireq_valid", bus.ireq.valid, 1);
      chk("addr_ireq_addr", bus.ireq.addr, pc);
      chk("addr_out_valid", out_valid, 0);
      chk("addr_in_ready", in_ready, 0);
      in_valid = 1'($urandom_range(0, 1));
      in_pc    = $urandom;
      if (i < a) begin
        bus.iresp.addr_ok = 1'b0;
        bus.iresp.data_ok = 1'($urandom_range(0, 1));
        bus.iresp.data    = ~word;
      end else begin
        bus.iresp.addr_ok = 1'b1;
        bus.iresp.data_ok = (d < 0);
        bus.iresp.data    = (d < 0) ? word : ~word;
      end
      step();
    end
    bus.iresp.addr_ok = 1'b0;
    bus.iresp.data_ok = 1'b0;
    in_valid = 1'b0;
    if (d >= 0) begin
      for (int i = 0; i <= d; i++) begin
        chk("data_ireq_valid", bus.ireq.valid, 0);
        chk("data_out_valid", out_valid, 0);
        if (i == d) begin
          bus.iresp.data_ok = 1'b1;
          bus.iresp.data    = word;
        end else begin
          bus.iresp.data    = $urandom;
        end
        step();
      end
    end
    bus.iresp.data_ok = 1'b0;
    exp_stall += 32'(a) + ((d > 0) ? 32'(d) : 32'd0);
    check_done(pc, word, 1'b0, hold);
  endtask

  task automatic fetch(input logic [31:0] pc, input int a, input int d,
                       input logic [31:0] word, input int hold);
    chk("idle_in_ready", in_ready, 1);
    in_valid = 1'b1;
    in_pc    = pc;
    if (pc[1:0] != 2'b00) begin
      step();
      in_valid = 1'b0;
      check_done(pc, 32'd0, 1'b1, hold);
    end else begin
      bus_fetch(pc, a, d, word, hold);
    end
  endtask

  logic [31:0] r_pc;
  int          r_a, r_d, r_h;

  initial begin
    bus.iresp = '0;

    // Boot fetch: addr_ok and data_ok in the first request cycle.
    reset = 1'b1;
    step(); step(); step();
    check_boot();
    reset = 1'b0;
    bus_fetch(RESET_PC, 0, -1, 32'h3c08_bfc0, 0);

    // Split handshake: 2 addr waits, data_ok 3 cycles after addr_ok.
    fetch(32'h8000_0010, 2, 2, $urandom, 0);

    // Misaligned PC: no bus activity.
    fetch(32'h8000_0002, 0, 0, 32'd0, 1);

    // Backpressure with next-PC wrap.
    fetch(32'hffff_fffc, 1, 0, $urandom, 5);

    // Randomized traffic.
    for (int k = 0; k < 24; k++) begin
      r_pc = $urandom;
      r_a  = int'($urandom_range(0, 3));
      r_d  = int'($urandom_range(0, 4)) - 1;
      r_h  = int'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) r_pc[1:0] = 2'b00;
      else if (r_pc[1:0] == 2'b00) r_pc[0] = 1'b1;
      fetch(r_pc, r_a, r_d, $urandom, r_h);
    end

    // Reset while waiting in S_DATA, then a stale data_ok after release.
    chk("pre_reset_in_ready", in_ready, 1);
    in_valid = 1'b1;
    in_pc    = 32'h8000_0100;
    step();
    in_valid = 1'b0;
    bus.iresp.addr_ok = 1'b1;
    step();
    bus.iresp.addr_ok = 1'b0;
    chk("mid_data_ireq_valid", bus.ireq.valid, 0);
    step();
    reset = 1'b1;
    bus.iresp.data_ok = 1'b1;
    bus.iresp.data    = 32'hdead_beef;
    step();
    check_boot();
    exp_stall = '0;
    reset = 1'b0;
    bus.iresp.data_ok = 1'b1;
    bus.iresp.data    = 32'hdead_beef;
    bus_fetch(RESET_PC, 2, 1, 32'h2408_0001, 1);

    fetch(32'h0000_0040, 0, -1, $urandom, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the reference multi-cycle CPU. It is the consumer of the next-PC value produced by branch evaluation or sequential PC increment. It commits that PC and issues one read on the instruction bus through its two-phase address/data handshake. It then returns the fetched word, together with its PC, to the decode stage over a valid/ready handshake.

## Interface
Parameters:
- RESET_PC, 32'hbfc0_0000, PC fetched automatically after reset

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  next-PC offer from branch/sequencer
- in_ready  out  1  unit idle, can accept in_pc
- in_pc  in  32  next PC to fetch
- ireq  out  ibus_req_t  {valid, addr}: instruction bus request
- iresp  in  ibus_resp_t  {addr_ok, data_ok, data}: instruction bus response
- out_valid  out  1  fetch result available
- out_ready  in  1  decode accepts result
- out_pc  out  32  PC of fetched instruction
- out_next_pc  out  32  out_pc + 4, modulo 2^32
- out_instr  out  32  fetched instruction; 0 when misaligned
- out_misaligned  out  1  in_pc[1:0] != 0, no bus access made
- perf_stall  out  32  cycles spent waiting on bus, wraps at 2^32

## Operation
- States: S_BOOT, S_IDLE, S_ADDR, S_DATA, S_DONE.
- Reset values:
  - Registers: state=S_BOOT, pc=RESET_PC, instr=0, misaligned=0, perf_stall=0.
  - Outputs during reset and in S_BOOT: ireq.valid=0, in_ready=0, out_valid=0.
- S_BOOT -> S_ADDR unconditionally. The first fetch is at RESET_PC and needs no in_valid.
- S_IDLE:
  - in_ready=1.
  - On in_valid, latch pc=in_pc.
  - If in_pc[1:0]!=0: misaligned=1, instr=0, go to S_DONE with no bus request.
  - Otherwise misaligned=0 and go to S_ADDR.
- S_ADDR:
  - ireq.valid=1, ireq.addr=pc. Both are held stable until addr_ok.
  - addr_ok&&data_ok: instr=iresp.data, go to S_DONE.
  - addr_ok only: go to S_DATA.
  - Neither: stay.
  - data_ok without addr_ok is ignored (stale response).
- S_DATA:
  - ireq.valid=0.
  - On data_ok: instr=iresp.data, go to S_DONE.
- S_DONE:
  - out_valid=1; out_pc, out_next_pc, out_instr and out_misaligned are driven from registers.
  - They are held stable while out_ready=0.
  - On out_ready, go to S_IDLE.
- in_ready=1 only in S_IDLE. in_valid in any other state is ignored, not queued.
- perf_stall:
  - Increments by 1 in every S_ADDR cycle without addr_ok and every S_DATA cycle without data_ok.
  - Wraps from 0xffff_ffff to 0.
- Arithmetic: out_next_pc = pc + 32'd4, truncated to 32 bits (0xffff_fffc -> 0x0000_0000).
- Reset mid-operation:
  - Abandons any outstanding transaction and returns to S_BOOT.
  - A data_ok for the abandoned request that arrives in S_BOOT or S_ADDR (without addr_ok) is ignored.

## Timing
- Accept at cycle N (in_valid && in_ready) -> ireq.valid=1 at N+1.
- Minimum latency, with addr_ok and data_ok both at N+1: out_valid=1 at N+2.
- Split handshake, addr_ok at N+1+a and data_ok at N+1+a+1+d: out_valid at N+3+a+d.
- Misaligned accept at N -> out_valid at N+1, with zero bus activity.
- Handoff at cycle M (out_valid && out_ready) -> in_ready=1 at M+1. No bypass from out_ready to in_ready.
- After reset deasserts at cycle R: S_BOOT at R, ireq.valid=1 with addr=RESET_PC at R+1.
- All outputs are registered-state decodes. There is no combinational path from in_valid or iresp to ireq.valid or in_ready.

## Test plan
- Boot fetch:
  - Stimulus: release reset; bus returns addr_ok&data_ok in the first request cycle with data=32'h3c08_bfc0.
  - Response: out_valid two cycles after reset release, out_pc=0xbfc0_0000, out_next_pc=0xbfc0_0004, out_instr=0x3c08bfc0, perf_stall=0.
- Split handshake with stalls:
  - Stimulus: in_pc=0x8000_0010; addr_ok after 2 wait cycles, data_ok 3 cycles later.
  - Response: ireq.addr held at 0x80000010 throughout, ireq.valid drops after addr_ok, perf_stall=4, out_instr equals the data_ok word.
- Misaligned PC:
  - Stimulus: in_pc=0x8000_0002.
  - Response: out_valid next cycle, out_misaligned=1, out_instr=0, ireq.valid never asserted.
- Backpressure and wrap:
  - Stimulus: in_pc=0xffff_fffc; hold out_ready=0 for 5 cycles.
  - Response: outputs stable throughout, out_next_pc=0x0000_0000, in_ready=0 until the cycle after out_ready=1.
- Reset mid-fetch:
  - Stimulus: assert reset in S_DATA; after release, drive a stale data_ok with no addr_ok.
  - Response: the stale word is not captured, ireq re-issues RESET_PC, perf_stall restarts from 0.
